// File: rtl/mips_enc_pkg.sv
// mips_enc_pkg: shared definitions for the MIPS-I instruction encoder.
//   - enc_op_t      : request kind driven on req_op (native ops + pseudo-ops)
//   - enc_state_t   : encoder FSM states
//   - OPC_* / FN_* / RI_* : MIPS-I primary opcode, SPECIAL funct and REGIMM rt codes
//   - r_type/i_type/j_type : field packing helpers
package mips_enc_pkg;

    typedef enum logic [5:0] {
        OP_ADD     = 6'd0,  OP_ADDU   = 6'd1,  OP_SUB    = 6'd2,  OP_SUBU   = 6'd3,
        OP_AND     = 6'd4,  OP_OR     = 6'd5,  OP_XOR    = 6'd6,  OP_NOR    = 6'd7,
        OP_SLT     = 6'd8,  OP_SLTU   = 6'd9,  OP_SLL    = 6'd10, OP_SRL    = 6'd11,
        OP_SRA     = 6'd12, OP_SLLV   = 6'd13, OP_SRLV   = 6'd14, OP_SRAV   = 6'd15,
        OP_JR      = 6'd16, OP_JALR   = 6'd17, OP_SYSCALL= 6'd18, OP_MFHI   = 6'd19,
        OP_MTHI    = 6'd20, OP_MFLO   = 6'd21, OP_MTLO   = 6'd22, OP_ADDI   = 6'd23,
        OP_ADDIU   = 6'd24, OP_SLTI   = 6'd25, OP_SLTIU  = 6'd26, OP_ANDI   = 6'd27,
        OP_ORI     = 6'd28, OP_XORI   = 6'd29, OP_LUI    = 6'd30, OP_LB     = 6'd31,
        OP_LH      = 6'd32, OP_LW     = 6'd33, OP_LBU    = 6'd34, OP_LHU    = 6'd35,
        OP_SB      = 6'd36, OP_SH     = 6'd37, OP_SW     = 6'd38, OP_BEQ    = 6'd39,
        OP_BNE     = 6'd40, OP_BLEZ   = 6'd41, OP_BGTZ   = 6'd42, OP_BLTZ   = 6'd43,
        OP_BGEZ    = 6'd44, OP_BLTZAL = 6'd45, OP_BGEZAL = 6'd46, OP_J      = 6'd47,
        OP_JAL     = 6'd48,
        // pseudo-ops
        OP_NOP     = 6'd49, OP_MOVE   = 6'd50, OP_LI     = 6'd51, OP_BLT    = 6'd52,
        OP_BGE     = 6'd53
    } enc_op_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } enc_state_t;

    // primary opcodes
    localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J     = 6'h02,
                           OPC_JAL     = 6'h03, OPC_BEQ    = 6'h04, OPC_BNE   = 6'h05,
                           OPC_BLEZ    = 6'h06, OPC_BGTZ   = 6'h07, OPC_ADDI  = 6'h08,
                           OPC_ADDIU   = 6'h09, OPC_SLTI   = 6'h0A, OPC_SLTIU = 6'h0B,
                           OPC_ANDI    = 6'h0C, OPC_ORI    = 6'h0D, OPC_XORI  = 6'h0E,
                           OPC_LUI     = 6'h0F, OPC_LB     = 6'h20, OPC_LH    = 6'h21,
                           OPC_LW      = 6'h23, OPC_LBU    = 6'h24, OPC_LHU   = 6'h25,
                           OPC_SB      = 6'h28, OPC_SH     = 6'h29, OPC_SW    = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
                           FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09,
                           FN_SYSCALL = 6'h0C, FN_MFHI = 6'h10, FN_MTHI = 6'h11,
                           FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                           FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                           FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    // REGIMM rt codes
    localparam logic [4:0] RI_BLTZ = 5'h00, RI_BGEZ = 5'h01, RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11;

    // $at, used as the compare scratch register by BLT/BGE
    localparam logic [4:0] REG_AT = 5'd1;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {OPC_SPECIAL, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [5:0] opc, input logic [25:0] tgt);
        return {opc, tgt};
    endfunction

endpackage

// File: rtl/mips_enc_pack.sv
// mips_enc_pack: combinational field packer and range checker.
//   i_op/i_rs/i_rt/i_rd/i_shamt/i_imm : request fields
//   o_word1, o_word2 : encoded words (o_word2 meaningful only with o_two_word)
//   o_two_word       : request expands to two words
//   o_illegal        : unknown op or immediate out of range
// Fields an instruction does not use are packed as zero.
module mips_enc_pack
    import mips_enc_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word1,
    output logic [31:0] o_word2,
    output logic        o_two_word,
    output logic        o_illegal
);

    logic        w_sext_ok;
    logic        w_zext_ok;
    logic        w_jmp_ok;
    logic [15:0] w_imm16;

    assign w_sext_ok = (i_imm[31:16] == {16{i_imm[15]}});
    assign w_zext_ok = (i_imm[31:16] == 16'h0000);
    assign w_jmp_ok  = (i_imm[31:26] == 6'b000000);
    assign w_imm16   = i_imm[15:0];

    // Decode the op into one or two words and flag range violations.
    always_comb begin
        o_word1    = 32'h0000_0000;
        o_word2    = 32'h0000_0000;
        o_two_word = 1'b0;
        o_illegal  = 1'b0;
        case (i_op)
            OP_ADD:     o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_ADD);
            OP_ADDU:    o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_ADDU);
            OP_SUB:     o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_SUB);
            OP_SUBU:    o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_SUBU);
            OP_AND:     o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_AND);
            OP_OR:      o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_OR);
            OP_XOR:     o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_XOR);
            OP_NOR:     o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_NOR);
            OP_SLT:     o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_SLT);
            OP_SLTU:    o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_SLTU);
            OP_SLL:     o_word1 = r_type(5'd0, i_rt, i_rd, i_shamt, FN_SLL);
            OP_SRL:     o_word1 = r_type(5'd0, i_rt, i_rd, i_shamt, FN_SRL);
            OP_SRA:     o_word1 = r_type(5'd0, i_rt, i_rd, i_shamt, FN_SRA);
            OP_SLLV:    o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_SLLV);
            OP_SRLV:    o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_SRLV);
            OP_SRAV:    o_word1 = r_type(i_rs, i_rt, i_rd, 5'd0, FN_SRAV);
            OP_JR:      o_word1 = r_type(i_rs, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_JALR:    o_word1 = r_type(i_rs, 5'd0, i_rd, 5'd0, FN_JALR);
            OP_SYSCALL: o_word1 = r_type(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
            OP_MFHI:    o_word1 = r_type(5'd0, 5'd0, i_rd, 5'd0, FN_MFHI);
            OP_MTHI:    o_word1 = r_type(i_rs, 5'd0, 5'd0, 5'd0, FN_MTHI);
            OP_MFLO:    o_word1 = r_type(5'd0, 5'd0, i_rd, 5'd0, FN_MFLO);
            OP_MTLO:    o_word1 = r_type(i_rs, 5'd0, 5'd0, 5'd0, FN_MTLO);
            OP_ADDI:    begin o_word1 = i_type(OPC_ADDI,  i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_ADDIU:   begin o_word1 = i_type(OPC_ADDIU, i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_SLTI:    begin o_word1 = i_type(OPC_SLTI,  i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_SLTIU:   begin o_word1 = i_type(OPC_SLTIU, i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_ANDI:    begin o_word1 = i_type(OPC_ANDI,  i_rs, i_rt, w_imm16); o_illegal = !w_zext_ok; end
            OP_ORI:     begin o_word1 = i_type(OPC_ORI,   i_rs, i_rt, w_imm16); o_illegal = !w_zext_ok; end
            OP_XORI:    begin o_word1 = i_type(OPC_XORI,  i_rs, i_rt, w_imm16); o_illegal = !w_zext_ok; end
            OP_LUI:     begin o_word1 = i_type(OPC_LUI,   5'd0, i_rt, w_imm16); o_illegal = !w_zext_ok; end
            OP_LB:      begin o_word1 = i_type(OPC_LB,    i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_LH:      begin o_word1 = i_type(OPC_LH,    i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_LW:      begin o_word1 = i_type(OPC_LW,    i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_LBU:     begin o_word1 = i_type(OPC_LBU,   i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_LHU:     begin o_word1 = i_type(OPC_LHU,   i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_SB:      begin o_word1 = i_type(OPC_SB,    i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_SH:      begin o_word1 = i_type(OPC_SH,    i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_SW:      begin o_word1 = i_type(OPC_SW,    i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_BEQ:     begin o_word1 = i_type(OPC_BEQ,   i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_BNE:     begin o_word1 = i_type(OPC_BNE,   i_rs, i_rt, w_imm16); o_illegal = !w_sext_ok; end
            OP_BLEZ:    begin o_word1 = i_type(OPC_BLEZ,  i_rs, 5'd0, w_imm16); o_illegal = !w_sext_ok; end
            OP_BGTZ:    begin o_word1 = i_type(OPC_BGTZ,  i_rs, 5'd0, w_imm16); o_illegal = !w_sext_ok; end
            OP_BLTZ:    begin o_word1 = i_type(OPC_REGIMM, i_rs, RI_BLTZ,   w_imm16); o_illegal = !w_sext_ok; end
            OP_BGEZ:    begin o_word1 = i_type(OPC_REGIMM, i_rs, RI_BGEZ,   w_imm16); o_illegal = !w_sext_ok; end
            OP_BLTZAL:  begin o_word1 = i_type(OPC_REGIMM, i_rs, RI_BLTZAL, w_imm16); o_illegal = !w_sext_ok; end
            OP_BGEZAL:  begin o_word1 = i_type(OPC_REGIMM, i_rs, RI_BGEZAL, w_imm16); o_illegal = !w_sext_ok; end
            OP_J:       begin o_word1 = j_type(OPC_J,   i_imm[25:0]); o_illegal = !w_jmp_ok; end
            OP_JAL:     begin o_word1 = j_type(OPC_JAL, i_imm[25:0]); o_illegal = !w_jmp_ok; end
            OP_NOP:     o_word1 = 32'h0000_0000;
            OP_MOVE:    o_word1 = r_type(i_rs, 5'd0, i_rd, 5'd0, FN_ADDU);
            OP_LI: begin
                // pick the shortest sequence that reproduces the 32-bit constant
                if (w_sext_ok) begin
                    o_word1 = i_type(OPC_ADDIU, 5'd0, i_rt, w_imm16);
                end else if (w_zext_ok) begin
                    o_word1 = i_type(OPC_ORI, 5'd0, i_rt, w_imm16);
                end else begin
                    o_word1    = i_type(OPC_LUI, 5'd0, i_rt, i_imm[31:16]);
                    o_word2    = i_type(OPC_ORI, i_rt, i_rt, w_imm16);
                    o_two_word = 1'b1;
                end
            end
            OP_BLT: begin
                // offset is taken relative to the branch, i.e. the second word
                o_word1    = r_type(i_rs, i_rt, REG_AT, 5'd0, FN_SLT);
                o_word2    = i_type(OPC_BNE, REG_AT, 5'd0, w_imm16);
                o_two_word = 1'b1;
                o_illegal  = !w_sext_ok;
            end
            OP_BGE: begin
                o_word1    = r_type(i_rs, i_rt, REG_AT, 5'd0, FN_SLT);
                o_word2    = i_type(OPC_BEQ, REG_AT, 5'd0, w_imm16);
                o_two_word = 1'b1;
                o_illegal  = !w_sext_ok;
            end
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_encode.sv
// mips_encode: MIPS-I instruction encoder with valid/ready request and output handshakes.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake; req_op/rs/rt/rd/shamt/imm are the fields
//   out_valid/out_ready     : encoded-word handshake, word on out_instr
//   err_illegal             : one-cycle pulse after a rejected request
// Holds the FSM, the output register and the second-word holding register;
// all packing lives in mips_enc_pack.
module mips_encode
    import mips_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err_illegal
);

    enc_state_t  r_state;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_word2;
    logic        r_err;

    enc_state_t  w_state_nxt;
    logic        w_out_valid_nxt;
    logic [31:0] w_out_instr_nxt;
    logic [31:0] w_word2_nxt;
    logic        w_err_nxt;

    logic [31:0] w_word1;
    logic [31:0] w_word2;
    logic        w_two_word;
    logic        w_illegal;
    logic        w_accept;
    logic        w_out_fire;

    mips_enc_pack u_pack (
        .i_op       (req_op),
        .i_rs       (req_rs),
        .i_rt       (req_rt),
        .i_rd       (req_rd),
        .i_shamt    (req_shamt),
        .i_imm      (req_imm),
        .o_word1    (w_word1),
        .o_word2    (w_word2),
        .o_two_word (w_two_word),
        .o_illegal  (w_illegal)
    );

    assign req_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = req_valid && req_ready;
    assign w_out_fire = r_out_valid && out_ready;

    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign err_illegal = r_err;

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid && !out_ready;
        w_out_instr_nxt = r_out_instr;
        w_word2_nxt     = r_word2;
        w_err_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_out_valid_nxt = 1'b1;
                        w_out_instr_nxt = w_word1;
                        if (w_two_word) begin
                            w_word2_nxt = w_word2;
                            w_state_nxt = ST_SECOND;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SECOND: begin
                // word 2 replaces word 1 on the very edge word 1 is taken
                if (w_out_fire) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_instr_nxt = r_word2;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SECOND;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any pending words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0000_0000;
            r_word2     <= 32'h0000_0000;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_word2     <= w_word2_nxt;
            r_err       <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_mips_encode.sv
// tb_mips_encode: scoreboard bench for mips_encode. Stimulus pushes hand-computed
// expected words (or an error marker) into a queue; a monitor pops and compares
// whenever the DUT completes an output handshake or pulses err_illegal.
module tb_mips_encode;
    import mips_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = 6'd0;
    logic [4:0]  req_rs = 5'd0, req_rt = 5'd0, req_rd = 5'd0, req_shamt = 5'd0;
    logic [31:0] req_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        err_illegal;

    int n_pass  = 0;
    int n_total = 0;

    // bit 32 set marks an expected err_illegal pulse
    logic [32:0] exp_q[$];
    localparam logic [32:0] ERR_MARK = {1'b1, 32'h0000_0000};

    mips_encode dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // monitor: compare every emitted word / error pulse against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (err_illegal) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_err: got err pulse expected nothing");
                end else begin
                    check("err_pulse", ERR_MARK, exp_q.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got %h expected nothing", out_instr);
                end else begin
                    check("out_word", {1'b0, out_instr}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back({1'b0, w});
    endtask

    task automatic push_err();
        exp_q.push_back(ERR_MARK);
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
        int n;
        req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
        req_shamt = sh; req_imm = imm;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                n_total++;
                $display("FAIL req_timeout: got req_ready=0 for 50 cycles expected 1");
                break;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 33'(exp_q.size()), 33'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {32'd0, out_valid},   33'd0);
        check("rst_out_instr", {1'b0, out_instr},    33'd0);
        check("rst_err",       {32'd0, err_illegal}, 33'd0);
        check("rst_req_ready", {32'd0, req_ready},   33'd1);
        @(posedge clk); #1;

        // single-word native ops, streamed with out_ready high
        push_word(32'h0022_1821); issue(OP_ADDU,   5'd1,  5'd2,  5'd3, 5'd0, 32'd0);
        push_word(32'h0003_1100); issue(OP_SLL,    5'd7,  5'd3,  5'd2, 5'd4, 32'd0);
        push_word(32'h24A6_FFFF); issue(OP_ADDIU,  5'd5,  5'd6,  5'd0, 5'd0, 32'hFFFF_FFFF);
        push_word(32'h8FBF_0008); issue(OP_LW,     5'd29, 5'd31, 5'd0, 5'd0, 32'd8);
        push_word(32'h0810_0000); issue(OP_J,      5'd0,  5'd0,  5'd0, 5'd0, 32'h0010_0000);
        push_word(32'h0471_0010); issue(OP_BGEZAL, 5'd3,  5'd0,  5'd0, 5'd0, 32'h0000_0010);

        // pseudo-ops
        push_word(32'h3C08_1234); push_word(32'h3508_5678);
        issue(OP_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
        @(negedge clk);
        check("li2_req_ready_low", {32'd0, req_ready}, 33'd0);
        @(posedge clk); #1;
        push_word(32'h2408_FFFF); issue(OP_LI,   5'd0,  5'd8, 5'd0, 5'd0, 32'hFFFF_FFFF);
        push_word(32'h3409_ABCD); issue(OP_LI,   5'd0,  5'd9, 5'd0, 5'd0, 32'h0000_ABCD);
        push_word(32'h0000_0000); issue(OP_NOP,  5'd31, 5'd7, 5'd9, 5'd3, 32'hDEAD_BEEF);
        push_word(32'h00A0_2021); issue(OP_MOVE, 5'd5,  5'd9, 5'd4, 5'd2, 32'd0);
        push_word(32'h0085_082A); push_word(32'h1020_0003);
        issue(OP_BGE, 5'd4, 5'd5, 5'd0, 5'd0, 32'd3);

        // rejected requests, each followed by a legal one
        push_err();               issue(OP_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0001_8000);
        @(negedge clk);
        check("illegal_no_valid", {32'd0, out_valid}, 33'd0);
        @(posedge clk); #1;
        push_word(32'h0022_1821); issue(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
        push_err();               issue(OP_ORI,  5'd1, 5'd2, 5'd0, 5'd0, 32'h0001_0000);
        push_err();               issue(OP_J,    5'd0, 5'd0, 5'd0, 5'd0, 32'h0400_0000);
        push_err();               issue(6'd63,   5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
        drain();

        // BLT with a stalled consumer: word 1 must hold for three cycles
        out_ready = 1'b0;
        push_word(32'h0085_082A); push_word(32'h1420_FFFE);
        issue(OP_BLT, 5'd4, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", {32'd0, out_valid}, 33'd1);
            check("stall_word",  {1'b0, out_instr},  {1'b0, 32'h0085_082A});
            check("stall_ready", {32'd0, req_ready}, 33'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // reset while the second word is still pending: nothing may come out
        out_ready = 1'b0;
        issue(OP_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
        @(negedge clk);
        check("pre_rst_valid", {32'd0, out_valid}, 33'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {32'd0, out_valid}, 33'd0);
        check("post_rst_instr", {1'b0, out_instr},  33'd0);
        check("post_rst_ready", {32'd0, req_ready}, 33'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {32'd0, out_valid}, 33'd0);
        end
        @(posedge clk); #1;

        // normal operation resumes
        push_word(32'h0022_1821); issue(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
